// File: rtl/gpio_pkg.sv
// Shared gpio constants: debounce defaults, synchronizer depth and counter sizing.
package gpio_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 4;
    localparam int unsigned DEF_TICK_DIV     = 1000;
    localparam int unsigned DEF_STABLE_TICKS = 10;
    localparam int unsigned SYNC_STAGES      = 2;

    // Debounce counter width; a single-tick threshold still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned stable_ticks);
        return (stable_ticks > 1) ? $clog2(stable_ticks) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: counts mismatching sample ticks and accepts a new level
// after STABLE_TICKS in a row, emitting a single-cycle rise or fall pulse.
module debounce_channel
    import gpio_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic tick,
    output logic sw_clean,
    output logic rise,
    output logic fall,
    output logic accept_c
);

    localparam int unsigned    CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [CW-1:0] cnt_q;
    logic          mismatch_c;

    assign mismatch_c = s ^ sw_clean;
    assign accept_c   = mismatch_c && tick && (cnt_q == CNT_LAST);

    // Any agreeing cycle clears the run, so a bounce never accumulates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            sw_clean <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            rise <= accept_c & s;
            fall <= accept_c & ~s;
            if (!mismatch_c) begin
                cnt_q <= '0;
            end else if (accept_c) begin
                cnt_q    <= '0;
                sw_clean <= s;
            end else if (tick) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer: synchronizer, shared sample-tick prescaler,
// per-channel debounce and a summary change pulse.
module sw_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sw_raw,
    output logic [DATA_WIDTH-1:0] sw_clean,
    output logic [DATA_WIDTH-1:0] rise,
    output logic [DATA_WIDTH-1:0] fall,
    output logic                  change
);

    localparam int unsigned    PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
    logic [PW-1:0]                          pre_q;
    logic                                   tick_c;
    logic [DATA_WIDTH-1:0]                  accept_c;

    // Metastability synchronizer on the raw board levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= sw_raw;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Free-running sample-tick prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    assign tick_c = (pre_q == PRE_LAST);

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .s        (sync_q[SYNC_STAGES-1][i]),
            .tick     (tick_c),
            .sw_clean (sw_clean[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .accept_c (accept_c[i])
        );
    end

    // Registered from the accept terms so it lines up with the rise/fall pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            change <= 1'b0;
        end else begin
            change <= |accept_c;
        end
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, giving the number of independent switch channels.
REQ-002 The block SHALL have parameter TICK_DIV, default 1000, giving the clk cycles per sample tick (legal range >=2).
REQ-003 The block SHALL have parameter STABLE_TICKS, default 10, giving the consecutive mismatching ticks needed to accept a new level (legal range >=1).
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port sw_raw, input, DATA_WIDTH bits: asynchronous board switch levels.
REQ-007 The block SHALL have port sw_clean, output, DATA_WIDTH bits: registered debounced levels that feed the gpio sw input.
REQ-008 The block SHALL have port rise, output, DATA_WIDTH bits: one-cycle pulse per channel when sw_clean goes 0->1.
REQ-009 The block SHALL have port fall, output, DATA_WIDTH bits: one-cycle pulse per channel when sw_clean goes 1->0.
REQ-010 The block SHALL have port change, output, 1 bit: registered OR of all rise and fall bits in the same cycle.

Function
REQ-011 Each sw_raw bit SHALL pass through a 2-flop synchronizer; s[i] is the second flop's output, two cycles after sampling.
REQ-012 A shared prescaler SHALL count 0..TICK_DIV-1, assert tick for one cycle when count == TICK_DIV-1, then wrap to 0; it is free-running and has no enable.
REQ-013 Per channel, when s[i] == sw_clean[i], cnt[i] SHALL clear to 0 on that cycle, tick or not (glitch rejection).
REQ-014 Per channel, when s[i] != sw_clean[i] and tick=1 and cnt[i] < STABLE_TICKS-1, cnt[i] SHALL increment by 1.
REQ-015 Per channel, when s[i] != sw_clean[i] and tick=1 and cnt[i] == STABLE_TICKS-1, then on that edge: sw_clean[i] SHALL take s[i], cnt[i] SHALL clear, and rise[i] or fall[i] SHALL go to 1 for exactly the next cycle.
REQ-016 Counter width SHALL be max(1, clog2(STABLE_TICKS)); prescaler width SHALL be clog2(TICK_DIV); neither counter SHALL ever exceed its terminal value.
REQ-017 Latency from a clean sw_raw edge to sw_clean SHALL be 2 + (STABLE_TICKS-1)*TICK_DIV + 1 cycles minimum and 2 + STABLE_TICKS*TICK_DIV cycles maximum, depending on prescaler phase.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle, and change SHALL be a single 1-cycle pulse.
REQ-019 rise[i] and fall[i] SHALL never be 1 in the same cycle; pulses SHALL be exactly one cycle long, even with STABLE_TICKS=1 and a constantly toggling input.
REQ-020 change SHALL be asserted in the same cycle as the rise and fall pulses it summarises.

Reset
REQ-021 When rst is asserted, sync flops, sw_clean, rise, fall, change, all cnt and the prescaler SHALL all go to 0 immediately, without waiting for clk.
REQ-022 A switch held at 1 through reset release SHALL be reported as a debounced rise after the REQ-017 latency, not immediately.
REQ-023 rst asserted mid-debounce SHALL discard partial counts, with no pulse on release unless the REQ-015 condition is met again after release.

Structure
REQ-024 Default parameter values and the synchronizer depth constant (2) SHALL live in the shared gpio_pkg package.
REQ-025 Per-channel logic (cnt, sw_clean bit, edge pulses) SHALL be the sub-module debounce_channel, instantiated DATA_WIDTH times.
REQ-026 The synchronizer, prescaler and change OR SHALL stay in sw_debounce.

Verification (TICK_DIV=4, STABLE_TICKS=3, DATA_WIDTH=4)
REQ-027 Reset release with sw_raw=0000 and no stimulus for 100 cycles -> sw_clean=0000 and no pulse on rise, fall or change.
REQ-028 sw_raw[0] 0->1 held -> sw_clean[0]=1 within 11..14 cycles; rise[0] and change each high exactly 1 cycle; fall stays 0.
REQ-029 sw_raw[1] at 1 for 6 cycles, then back to 0 (bounce shorter than the threshold) -> sw_clean[1] stays 0, no pulse, cnt[1] returns to 0.
REQ-030 sw_raw 0000->1111 in one cycle -> rise=1111 for one cycle, in the same cycle for all channels, with one change pulse; then 1111->0101 -> fall=1010 for one cycle.
REQ-031 rst asserted for 1 cycle at cnt[2]=2 with sw_raw[2]=1 -> all outputs 0 at once; sw_clean[2] rises only a full 11..14 cycles after release.
